packet_transmitter: RTL
=======================

# packet_transmitter

Transmit end of the serializer's word-packet link: takes tagged 32-bit words from the packing datapath, buffers them in a small FIFO, and drives them onto the valid/ready packet interface with start-of-packet and end-of-packet markers. It is the sending counterpart of the receiver, which accepts `valid`/`sop`/`eop`/`data` and produces first/last/new-word strobes. The block also enforces packet framing on its input, counts completed packets, and flags framing and overflow errors.

## Interface
- `WIDTH`, 32: data word width.
- `DEPTH`, 4: number of FIFO entries; must be a power of 2 and at least 2.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `word_t`  in  WIDTH  word to send.
- `new_word_t`  in  1  push strobe; `word_t`, `first_word_t` and `last_word_t` are valid in this cycle.
- `first_word_t`  in  1  word is the first of its packet.
- `last_word_t`  in  1  word is the last of its packet; may be set together with `first_word_t`.
- `full_t`  out  1  FIFO holds DEPTH entries.
- `ready_in`  in  1  downstream can accept a word this cycle.
- `valid_out`  out  1  `data_out`, `sop_out` and `eop_out` are valid.
- `data_out`  out  WIDTH  word on the link.
- `sop_out`  out  1  start of packet.
- `eop_out`  out  1  end of packet.
- `pkt_count`  out  8  number of packets whose eop word has been transferred; wraps modulo 256.
- `err_frame`  out  1  sticky framing-error flag.
- `err_ovf`  out  1  sticky overflow flag.

## Operation
- **FIFO entries:** each entry is {sop, eop, word}, read first-word-fall-through. `valid_out` = not empty. `data_out`, `sop_out` and `eop_out` always show the head entry.
- **Push rule:** a push is accepted when `new_word_t` = 1, `full_t` = 0 and the framing FSM allows the word.
- **Push while full:** the word is dropped and `err_ovf` is set. This applies even if a pop happens in the same cycle.
- **Pop rule:** a pop occurs when `valid_out` = 1 and `ready_in` = 1.
- **Simultaneous push and pop:** occupancy is unchanged. Read and write pointers wrap modulo DEPTH.
- **Framing FSM (input side):** two states, IDLE and IN_PKT; reset state is IDLE.
  - IDLE, word with `first_word_t` = 1 and `last_word_t` = 0: accept with sop=1, go to IN_PKT.
  - IDLE, word with `first_word_t` = 1 and `last_word_t` = 1: accept with sop=1, eop=1, stay in IDLE.
  - IDLE, word with `first_word_t` = 0: drop the word and set `err_frame`.
  - IN_PKT, word with both tags 0: accept as a middle word.
  - IN_PKT, word with `last_word_t` = 1: accept with eop=1, go to IDLE.
  - IN_PKT, word with `first_word_t` = 1: drop the word, set `err_frame`, stay in IN_PKT.
  - A word dropped for overflow does not change the FSM state.
- **Packet counter:** `pkt_count` increments on each pop of an entry with eop=1, and wraps from 255 to 0.
- **Error flags:** `err_frame` and `err_ovf` stay set until `rst`.

## Timing
- **Reset values:** `valid_out`=0, `data_out`=0, `sop_out`=0, `eop_out`=0, `full_t`=0, `pkt_count`=0, `err_frame`=0, `err_ovf`=0. The FIFO is empty and the FSM is in IDLE.
- **Latency:** a word pushed at edge N is presented at the link (`valid_out`=1) after edge N, provided the FIFO was empty. Minimum latency is 1 cycle.
- **Hold rule:** once `valid_out` rises, `data_out`, `sop_out` and `eop_out` stay stable until the pop edge.
- **No combinational path:** `ready_in` has no combinational path to any output. All outputs are registered or decoded from registered state.
- **Throughput:** with `ready_in` held at 1 and one push per cycle, the block sustains one word per cycle with no bubbles.
- **`full_t` timing:** `full_t` reflects occupancy after the previous edge. Upstream must not rely on same-cycle pops freeing space.
- **Reset mid-packet:** all buffered words are discarded, `valid_out` falls after the reset edge, and the FSM returns to IDLE. A partial packet is never completed.
- **Reset priority:** `rst` takes priority over push and pop in the same cycle.

## Test plan
- **Reset defaults:** hold `rst` for 2 cycles with `new_word_t` pulsing → all outputs read 0 and nothing is buffered.
- **Four-word packet:** push F00CC05A (first), 7D000007, 00000020, FE000000 (last) with `ready_in`=1 → link carries the same four words on consecutive cycles, `sop_out` only on F00CC05A, `eop_out` only on FE000000. `pkt_count` becomes 1.
- **Backpressure:** same packet with `ready_in`=0 for 3 cycles after the first word is presented → head F00CC05A is held stable. Pushes continue until `full_t`=1 at 4 entries. A 5th push sets `err_ovf` and that word never appears on the link.
- **Framing errors:** in IDLE, push 12345678 without `first_word_t` → dropped, `err_frame`=1. Then push A0000001 (first), then B0000002 (first) → B0000002 dropped and the FSM stays in IN_PKT.
- **Single-word packet and wrap:** push 300 words with `first_word_t`=`last_word_t`=1 → each appears with `sop_out`=`eop_out`=1, and `pkt_count` wraps to 44.
- **Reset mid-packet:** push two words of a packet with `ready_in`=0, then assert `rst` → `valid_out`=0 after the reset edge. A following fresh packet transmits correctly with `pkt_count` starting from 0.

Source files
------------

// File: rtl/packet_transmitter.sv
// Transmit end of the word-packet link: framing check on the input, a small
// first-word-fall-through FIFO, and valid/ready output with sop/eop markers.
module packet_transmitter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_t,
    input  logic             new_word_t,
    input  logic             first_word_t,
    input  logic             last_word_t,
    output logic             full_t,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             sop_out,
    output logic             eop_out,
    output logic [7:0]       pkt_count,
    output logic             err_frame,
    output logic             err_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        IN_PKT
    } frame_state_t;

    // Entry layout: {sop, eop, word}
    logic [WIDTH+1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    frame_state_t     state;

    logic frame_ok;
    logic push;
    logic pop;

    // Outputs decode registered state only, so ready_in never reaches them.
    assign valid_out = (count != '0);
    assign full_t    = (count == FULL_COUNT);
    assign data_out  = mem[rd_ptr][WIDTH-1:0];
    assign eop_out   = mem[rd_ptr][WIDTH];
    assign sop_out   = mem[rd_ptr][WIDTH+1];

    // Outside a packet only a first word is legal; inside, a first word is not.
    always_comb begin
        frame_ok = (state == IDLE) ? first_word_t : !first_word_t;
        push     = new_word_t && !full_t && frame_ok;
        pop      = valid_out && ready_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            state     <= IDLE;
            pkt_count <= '0;
            err_frame <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {first_word_t, last_word_t, word_t};
                wr_ptr      <= wr_ptr + 1'b1;
                state       <= last_word_t ? IDLE : IN_PKT;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (mem[rd_ptr][WIDTH]) begin
                    pkt_count <= pkt_count + 8'd1;
                end
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Overflow is judged first; such a word never reaches the framing check.
            if (new_word_t && full_t) begin
                err_ovf <= 1'b1;
            end else if (new_word_t && !frame_ok) begin
                err_frame <= 1'b1;
            end
        end
    end

endmodule
